// File: rtl/bcd_timer_core.sv
// bcd_timer_core: N-digit BCD up/down timer with tick prescaler, pause and DONE state.
// Define TIMER_DONE_BLINK_EN to blink the LED bar once per tick while in DONE.
module bcd_timer_core #(
    parameter int DIGITS   = 2,
    parameter int TICK_DIV = 100000000,
    parameter int LEDS_N   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic                restart,
    input  logic                mode,
    input  logic [4*DIGITS-1:0] load_value,
    output logic [4*DIGITS-1:0] count,
    output logic                running,
    output logic                paused,
    output logic                done,
    output logic [LEDS_N-1:0]   leds
);
    localparam int W = 4*DIGITS;
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV-1);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
    state_t state_q, state_d;
    logic [W-1:0] count_q, count_d, lim, lim_q, lim_d, init, term, nxt;
    logic [PW-1:0] pre_q, pre_d;
    logic [LEDS_N-1:0] leds_q, leds_d;
    logic mode_q, mode_d, tick, running_q, paused_q, done_q;

    function automatic logic [W-1:0] bcd_step(input logic [W-1:0] v, input logic up);
        logic [W-1:0] r;
        logic c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (up) begin
                    c = v[4*i+:4] == 4'd9;
                    r[4*i+:4] = c ? 4'd0 : v[4*i+:4] + 4'd1;
                end else begin
                    c = v[4*i+:4] == 4'd0;
                    r[4*i+:4] = c ? 4'd9 : v[4*i+:4] - 4'd1;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        lim = load_value;
        for (int i = 0; i < DIGITS; i++)
            lim[4*i+:4] = load_value[4*i+:4] > 4'd9 ? 4'd9 : load_value[4*i+:4];
    end

    assign init = mode ? '0 : lim;
    assign term = mode_q ? lim_q : '0;
    assign nxt  = bcd_step(count_q, mode_q);
    assign tick = pre_q == PMAX;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pre_d   = pre_q;
        mode_d  = mode_q;
        lim_d   = lim_q;
        if (restart) begin
            state_d = IDLE;
            pre_d   = '0;
            count_d = init;
        end else begin
            case (state_q)
                IDLE: begin
                    count_d = init;
                    pre_d   = '0;
                    if (push) begin
                        mode_d  = mode;
                        lim_d   = lim;
                        // start equals terminal in either direction exactly when lim is zero
                        state_d = lim == '0 ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (push) state_d = PAUSE;
                    else begin
                        pre_d = tick ? '0 : pre_q + 1'b1;
                        if (tick) begin
                            count_d = nxt;
                            if (nxt == term) state_d = DONE;
                        end
                    end
                end
                PAUSE: if (push) state_d = RUN;
                DONE: begin
`ifdef TIMER_DONE_BLINK_EN
                    pre_d = tick ? '0 : pre_q + 1'b1;
`endif
                end
            endcase
        end
        leds_d = state_d == RUN || state_d == DONE ? '1 : state_d == PAUSE ? LEDS_N'(1) : '0;
`ifdef TIMER_DONE_BLINK_EN
        if (state_q == DONE && state_d == DONE) leds_d = tick ? ~leds_q : leds_q;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            pre_q     <= '0;
            mode_q    <= 1'b0;
            lim_q     <= '0;
            leds_q    <= '0;
            running_q <= 1'b0;
            paused_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            pre_q     <= pre_d;
            mode_q    <= mode_d;
            lim_q     <= lim_d;
            leds_q    <= leds_d;
            running_q <= state_d == RUN;
            paused_q  <= state_d == PAUSE;
            done_q    <= state_d == DONE;
        end
    end

    assign count   = count_q;
    assign running = running_q;
    assign paused  = paused_q;
    assign done    = done_q;
    assign leds    = leds_q;
endmodule

// File: tb/tb_bcd_timer_core.sv
// tb_bcd_timer_core: table, directed and randomized checks of bcd_timer_core against an integer model.
module tb_bcd_timer_core;
    localparam int TD = 4;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

    logic clk = 1'b0, rst = 1'b0, push = 1'b0, restart = 1'b0, mode = 1'b0;
    logic [7:0] load_value = 8'h00;
    logic [7:0] count;
    logic running, paused, done;
    logic [15:0] leds;
    int checks = 0, failures = 0;
    int m_st = S_IDLE, m_val = 0, m_pre = 0, m_lim = 0, m_dcnt = 0;
    bit m_mode = 1'b0;

    bcd_timer_core #(.DIGITS(2), .TICK_DIV(TD), .LEDS_N(16)) dut (
        .clk(clk), .rst(rst), .push(push), .restart(restart), .mode(mode),
        .load_value(load_value), .count(count), .running(running),
        .paused(paused), .done(done), .leds(leds)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       md;
        logic [7:0] lv;
        logic [7:0] exp;
    } vec_t;

    function automatic int lim_of(input logic [7:0] v);
        int hi, lo;
        hi = v[7:4] > 4'd9 ? 9 : int'(v[7:4]);
        lo = v[3:0] > 4'd9 ? 9 : int'(v[3:0]);
        return hi*10 + lo;
    endfunction

    function automatic logic [7:0] to_bcd(input int x);
        return {4'(x/10), 4'(x%10)};
    endfunction

    function automatic logic [15:0] exp_leds();
        if (m_st == S_RUN) return 16'hFFFF;
        if (m_st == S_PAUSE) return 16'h0001;
        if (m_st == S_DONE) begin
`ifdef TIMER_DONE_BLINK_EN
            return ((m_dcnt/TD) % 2) != 0 ? 16'h0000 : 16'hFFFF;
`else
            return 16'hFFFF;
`endif
        end
        return 16'h0000;
    endfunction

    task automatic model_edge();
        int l, ini;
        l = lim_of(load_value);
        ini = mode ? 0 : l;
        if (restart) begin
            m_st = S_IDLE; m_pre = 0; m_val = ini;
        end else begin
            case (m_st)
                S_IDLE: begin
                    m_val = ini; m_pre = 0;
                    if (push) begin
                        m_mode = mode; m_lim = l; m_dcnt = 0;
                        m_st = (ini == (mode ? l : 0)) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (push) m_st = S_PAUSE;
                    else if (m_pre == TD-1) begin
                        m_pre = 0;
                        m_val = m_val + (m_mode ? 1 : -1);
                        if (m_val == (m_mode ? m_lim : 0)) begin m_st = S_DONE; m_dcnt = 0; end
                    end else m_pre++;
                end
                S_PAUSE: if (push) m_st = S_RUN;
                default: m_dcnt++;
            endcase
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit p, input bit r, input bit md, input logic [7:0] lv);
        push = p; restart = r; mode = md; load_value = lv;
        @(posedge clk);
        model_edge();
        #1;
        chk("model", {37'd0, count, running, paused, done, leds},
            {37'd0, to_bcd(m_val), m_st == S_RUN, m_st == S_PAUSE, m_st == S_DONE, exp_leds()});
    endtask

    vec_t tbl[6];

    initial begin
        tbl[0] = '{1'b0, 8'h12, 8'h12};
        tbl[1] = '{1'b0, 8'hAF, 8'h99};
        tbl[2] = '{1'b1, 8'hAF, 8'h00};
        tbl[3] = '{1'b0, 8'h5C, 8'h59};
        tbl[4] = '{1'b0, 8'hA3, 8'h93};
        tbl[5] = '{1'b0, 8'h00, 8'h00};

        #2 rst = 1'b1;
        #1 chk("reset", {count, running, paused, done, leds}, 27'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            step(0, 0, tbl[i].md, tbl[i].lv);
            chk("sanitize", count, tbl[i].exp);
        end

        // countdown from 12, four cycles per step
        step(0, 0, 0, 8'h12);
        step(1, 0, 0, 8'h12);
        chk("down_start", {count, running}, {8'h12, 1'b1});
        for (int v = 11; v >= 0; v--) begin
            repeat (TD) step(0, 0, 0, 8'h12);
            chk("down_step", count, to_bcd(v));
        end
        chk("down_done", {done, running, leds}, {1'b1, 1'b0, 16'hFFFF});
        step(1, 0, 0, 8'h12);
        chk("done_push_ignored", {count, done}, {8'h00, 1'b1});

        // count up to 15 with BCD carry
        step(0, 1, 1, 8'h15);
        step(1, 0, 1, 8'h15);
        for (int v = 1; v <= 15; v++) begin
            repeat (TD) step(0, 0, 1, 8'h15);
            chk("up_step", count, to_bcd(v));
            if (v == 10) chk("up_carry", count, 8'h10);
        end
        chk("up_done", done, 1'b1);
        repeat (8) step(0, 0, 0, 8'h99);
        chk("up_hold", {count, done}, {8'h15, 1'b1});

        // pause with prescaler frozen at 2
        step(0, 1, 0, 8'h12);
        step(1, 0, 0, 8'h12);
        repeat (6) step(0, 0, 0, 8'h12);
        step(1, 0, 0, 8'h12);
        chk("paused", {count, paused, leds}, {8'h11, 1'b1, 16'h0001});
        repeat (20) step(0, 0, 1, 8'h77);
        chk("pause_frozen", count, 8'h11);
        step(1, 0, 0, 8'h12);
        step(0, 0, 0, 8'h12);
        chk("resume_1", {count, running}, {8'h11, 1'b1});
        step(0, 0, 0, 8'h12);
        chk("resume_tick", count, 8'h10);

        // restart beats push
        step(1, 1, 0, 8'h12);
        chk("restart_prio", {count, running, done, leds}, {8'h12, 1'b0, 1'b0, 16'h0});
        step(0, 0, 0, 8'h12);

        // zero load goes straight to DONE
        step(0, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00);
        chk("zero_done", {count, done, running}, {8'h00, 1'b1, 1'b0});
        repeat (9) step(0, 0, 0, 8'h00);
        chk("zero_hold", count, 8'h00);

        // asynchronous reset mid-run
        step(0, 1, 0, 8'h12);
        step(1, 0, 0, 8'h12);
        repeat (5) step(0, 0, 0, 8'h12);
        #2 rst = 1'b1;
        #1 chk("async_rst", {count, running, leds}, 25'd0);
        m_st = S_IDLE; m_val = 0; m_pre = 0; m_mode = 1'b0; m_lim = 0;
        @(negedge clk);
        rst = 1'b0;

        begin
            bit md;
            logic [7:0] lv;
            md = 1'b0;
            lv = 8'h05;
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(0, 15) == 0) lv = 8'($urandom);
                if ($urandom_range(0, 15) == 0) md = 1'($urandom);
                step($urandom_range(0, 9) == 0, $urandom_range(0, 79) == 0, md, lv);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
